ram_port_arbiter: RTL and testbench

- Shares one single-port, byte-writable synchronous block RAM between two requesters: the core instruction-fetch port (read-only) and the load/store data port (read/write).
- The RAM has a 1-cycle read latency. The block arbitrates round-robin each cycle, drives the RAM address, byte-enable and write-data lines, and routes the returned word to the requester that owns it.
- Sits between the core memory ports and the RAM wrapper (RAM side maps onto the ram_rw_io MASTER fields we, addr, wdata, rdata).

---
 rtl/ram_arb_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/ram_port_arbiter.sv | 82 ++++++++
 tb/tb_ram_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port block-RAM arbiter.
// Grant index 0 is the instruction-fetch port, index 1 the load/store port.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_INSTR = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

   localparam logic GNT_INSTR = 1'b0;
   localparam logic GNT_DATA  = 1'b1;

   localparam int RAM_ADDR_WIDTH = 10;
   localparam int RAM_DATA_WIDTH = 32;

   // Maps a one-hot grant vector onto the requester that owns the next RAM response.
   function automatic owner_e owner_from_gnt(input logic [1:0] gnt);
      owner_e owner;
      owner = OWN_NONE;
      if (gnt[GNT_INSTR]) begin
         owner = OWN_INSTR;
      end else if (gnt[GNT_DATA]) begin
         owner = OWN_DATA;
      end
      return owner;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter; the last-grant register lives in the parent
// so this block can front any shared slave.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         // On contention the requester that did not win last time goes next.
         2'b11:   gnt = (last_gnt == GNT_INSTR) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port, byte-writable, 1-cycle-latency block RAM between the
// instruction-fetch port and the load/store port with round-robin arbitration.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,

   input  logic                    instr_req_i,
   input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
   output logic                    instr_gnt_o,
   output logic                    instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]   instr_rdata_o,

   input  logic                    data_req_i,
   input  logic [DATA_WIDTH/8-1:0] data_we_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,

   output logic [DATA_WIDTH/8-1:0] ram_we_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

   logic [1:0] req;
   logic [1:0] gnt;
   logic       last_gnt;
   owner_e     owner_p1;

   // Masking requests during reset suppresses grants, RAM writes and last_gnt updates at once.
   assign req = {data_req_i, instr_req_i} & {2{~rst_i}};

   rr_arb2 u_rr_arb2 (
      .req      (req),
      .last_gnt (last_gnt),
      .gnt      (gnt)
   );

   assign instr_gnt_o = gnt[GNT_INSTR];
   assign data_gnt_o  = gnt[GNT_DATA];

   always_comb begin
      ram_we_o    = '0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (gnt[GNT_INSTR]) begin
         ram_addr_o = instr_addr_i;
      end else if (gnt[GNT_DATA]) begin
         ram_addr_o  = data_addr_i;
         ram_we_o    = data_we_i;
         ram_wdata_o = data_wdata_i;
      end
   end

   // Grant stage -> response stage: remember who owns the word the RAM returns next cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_gnt <= GNT_DATA;
         owner_p1 <= OWN_NONE;
      end else begin
         if (|gnt) begin
            last_gnt <= gnt[GNT_DATA];
         end
         owner_p1 <= owner_from_gnt(gnt);
      end
   end

   // Response stage is driven straight from owner_p1, so a grant issued just before
   // reset still delivers its rvalid during the first reset cycle.
   assign instr_rvalid_o = (owner_p1 == OWN_INSTR);
   assign data_rvalid_o  = (owner_p1 == OWN_DATA);
   assign instr_rdata_o  = instr_rvalid_o ? ram_rdata_i : '0;
   assign data_rdata_o   = data_rvalid_o  ? ram_rdata_i : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a byte-writable 1-cycle-latency RAM model.
module tb_ram_port_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          instr_req_i;
   logic [AW-1:0] instr_addr_i;
   logic          instr_gnt_o;
   logic          instr_rvalid_o;
   logic [DW-1:0] instr_rdata_o;
   logic          data_req_i;
   logic [BW-1:0] data_we_i;
   logic [AW-1:0] data_addr_i;
   logic [DW-1:0] data_wdata_i;
   logic          data_gnt_o;
   logic          data_rvalid_o;
   logic [DW-1:0] data_rdata_o;
   logic [BW-1:0] ram_we_o;
   logic [AW-1:0] ram_addr_o;
   logic [DW-1:0] ram_wdata_o;
   logic [DW-1:0] ram_rdata_i;

   ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .data_req_i     (data_req_i),
      .data_we_i      (data_we_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .ram_we_o       (ram_we_o),
      .ram_addr_o     (ram_addr_o),
      .ram_wdata_o    (ram_wdata_o),
      .ram_rdata_i    (ram_rdata_i)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(input int a);
      if (a == 4)  return 32'h0000_0013;
      if (a == 16) return 32'h1122_3344;
      return 32'hC0DE_0000 | DW'(a);
   endfunction

   // RAM model: read-before-write, byte write enables, 1-cycle read latency.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic          ram_init = 1'b0;
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
         ram_init <= 1'b1;
      end else begin
         for (int b = 0; b < BW; b++)
            if (ram_we_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
      end
      ram_rdata_i <= mem[ram_addr_o];
   end

   typedef struct {
      logic          wr;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t          iq[$];
   exp_t          dq[$];
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   logic [DW-1:0] last_drd;
   int            cyc;
   int            n_tests;
   int            n_fail;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // One clock: check responses, then grants and RAM drive, at the falling edge.
   task automatic tick(input logic ei, input logic ed);
      exp_t e;
      @(negedge clk);
      if (instr_rvalid_o) begin
         if (iq.size() == 0) check_eq("instr_rvalid_spurious", 1, 0);
         else begin
            e = iq.pop_front();
            check_eq("instr_latency", 64'(cyc), 64'(e.cyc + 1));
            check_eq("instr_rdata", instr_rdata_o, e.data);
         end
      end else begin
         check_eq("instr_rdata_idle", instr_rdata_o, 0);
         if (iq.size() != 0) begin
            e = iq.pop_front();
            check_eq("instr_rvalid_missing", 0, 1);
         end
      end
      if (data_rvalid_o) begin
         if (dq.size() == 0) check_eq("data_rvalid_spurious", 1, 0);
         else begin
            e = dq.pop_front();
            check_eq("data_latency", 64'(cyc), 64'(e.cyc + 1));
            if (!e.wr) begin
               check_eq("data_rdata", data_rdata_o, e.data);
               last_drd = data_rdata_o;
            end
         end
      end else begin
         check_eq("data_rdata_idle", data_rdata_o, 0);
         if (dq.size() != 0) begin
            e = dq.pop_front();
            check_eq("data_rvalid_missing", 0, 1);
         end
      end
      check_eq("instr_gnt", instr_gnt_o, ei);
      check_eq("data_gnt", data_gnt_o, ed);
      if (instr_gnt_o) begin
         check_eq("ram_addr_instr", ram_addr_o, instr_addr_i);
         check_eq("ram_we_instr", ram_we_o, 0);
         iq.push_back('{wr: 1'b0, data: shadow[instr_addr_i], cyc: cyc});
      end else if (data_gnt_o) begin
         check_eq("ram_addr_data", ram_addr_o, data_addr_i);
         check_eq("ram_we_data", ram_we_o, data_we_i);
         check_eq("ram_wdata_data", ram_wdata_o, data_wdata_i);
         if (data_we_i != '0) begin
            for (int b = 0; b < BW; b++)
               if (data_we_i[b]) shadow[data_addr_i][b*8 +: 8] = data_wdata_i[b*8 +: 8];
            dq.push_back('{wr: 1'b1, data: '0, cyc: cyc});
         end else begin
            dq.push_back('{wr: 1'b0, data: shadow[data_addr_i], cyc: cyc});
         end
      end else begin
         check_eq("ram_we_idle", ram_we_o, 0);
         check_eq("ram_addr_idle", ram_addr_o, 0);
         check_eq("ram_wdata_idle", ram_wdata_o, 0);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      cyc = 0;
      last_drd = '0;
      for (int i = 0; i < (1 << AW); i++) shadow[i] = init_word(i);
      rst_i = 1'b1;
      instr_req_i = 1'b0;
      instr_addr_i = '0;
      data_req_i = 1'b0;
      data_we_i = '0;
      data_addr_i = '0;
      data_wdata_i = '0;
      @(posedge clk);
      #1;

      // Reset state
      tick(0, 0);
      tick(0, 0);
      check_eq("rst_instr_rvalid", instr_rvalid_o, 0);
      check_eq("rst_data_rvalid", data_rvalid_o, 0);
      check_eq("rst_ram_we", ram_we_o, 0);
      check_eq("rst_ram_addr", ram_addr_o, 0);

      // Idle after release
      rst_i = 1'b0;
      for (int i = 0; i < 10; i++) tick(0, 0);

      // Single fetch
      instr_req_i = 1'b1;
      instr_addr_i = 10'h004;
      tick(1, 0);
      instr_req_i = 1'b0;
      tick(0, 0);

      // Partial write then read-back
      data_req_i = 1'b1;
      data_addr_i = 10'h010;
      data_we_i = 4'b0011;
      data_wdata_i = 32'hAABB_CCDD;
      tick(0, 1);
      data_we_i = '0;
      data_wdata_i = '0;
      tick(0, 1);
      data_req_i = 1'b0;
      tick(0, 0);
      check_eq("write_merge", last_drd, 32'h1122_CCDD);

      // Continuous contention from reset
      rst_i = 1'b1;
      tick(0, 0);
      tick(0, 0);
      rst_i = 1'b0;
      instr_req_i = 1'b1;
      data_req_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         instr_addr_i = AW'(i + 32);
         data_addr_i = AW'(3 * i + 100);
         tick((i % 2) == 0, (i % 2) == 1);
      end
      instr_req_i = 1'b0;
      data_req_i = 1'b0;
      tick(0, 0);

      // Reset right after a data grant
      data_req_i = 1'b1;
      data_addr_i = 10'h010;
      tick(0, 1);
      rst_i = 1'b1;
      instr_req_i = 1'b1;
      tick(0, 0);
      tick(0, 0);
      rst_i = 1'b0;
      tick(1, 0);
      instr_req_i = 1'b0;
      data_req_i = 1'b0;
      tick(0, 0);

      // Data-only stream, then contention
      data_req_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data_addr_i = AW'(200 + i);
         data_we_i = (i % 2 == 0) ? 4'hF : 4'h0;
         data_wdata_i = 32'h5A5A_0000 | DW'(i);
         tick(0, 1);
      end
      data_we_i = '0;
      data_addr_i = 10'h0C8;
      instr_req_i = 1'b1;
      instr_addr_i = 10'h3FF;
      tick(1, 0);
      tick(0, 1);
      instr_req_i = 1'b0;
      data_req_i = 1'b0;
      tick(0, 0);
      tick(0, 0);

      check_eq("instr_queue_drained", 64'(iq.size()), 0);
      check_eq("data_queue_drained", 64'(dq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
